md_io_regs: RTL and testbench

MD_IO_REGS -- requirements
Module: md_io_regs

---
 rtl/md_io_pkg.sv | 49 ++++
 rtl/md_io_channel.sv | 77 +++++++
 rtl/md_io_regs.sv | 105 ++++++++++
 tb/tb_md_io_regs.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/md_io_pkg.sv
// Shared register indices, reset values and address decode helpers for the
// console I/O port register block.
package md_io_pkg;

  localparam logic [3:0] ADDR_VERSION = 4'h0;
  localparam logic [3:0] ADDR_DATA1   = 4'h1;
  localparam logic [3:0] ADDR_DATA2   = 4'h2;
  localparam logic [3:0] ADDR_DATA3   = 4'h3;
  localparam logic [3:0] ADDR_CTRL1   = 4'h4;
  localparam logic [3:0] ADDR_CTRL2   = 4'h5;
  localparam logic [3:0] ADDR_CTRL3   = 4'h6;

  localparam logic [7:0] DATA_RST  = 8'h7F;
  localparam logic [7:0] CTRL_RST  = 8'h00;
  localparam logic [7:0] TXDATA_RD = 8'hFF;
  localparam logic [7:0] RXDATA_RD = 8'h00;
  localparam logic [7:0] SCTRL_RD  = 8'h00;
  localparam logic [6:0] SYNC_RST  = 7'h7F;

  typedef enum logic [2:0] {
    REG_VERSION,
    REG_DATA,
    REG_CTRL,
    REG_TXDATA,
    REG_RXDATA,
    REG_SCTRL
  } reg_kind_e;

  function automatic reg_kind_e decode_kind(input logic [3:0] a);
    case (a)
      ADDR_VERSION:                   return REG_VERSION;
      ADDR_DATA1, ADDR_DATA2, ADDR_DATA3: return REG_DATA;
      ADDR_CTRL1, ADDR_CTRL2, ADDR_CTRL3: return REG_CTRL;
      4'h7, 4'hA, 4'hD:               return REG_TXDATA;
      4'h8, 4'hB, 4'hE:               return REG_RXDATA;
      default:                        return REG_SCTRL;
    endcase
  endfunction

  // Port index (0..2) for DATA/CTRL addresses; don't-care elsewhere.
  function automatic logic [1:0] port_index(input logic [3:0] a);
    case (a)
      ADDR_DATA1, ADDR_CTRL1: return 2'd0;
      ADDR_DATA2, ADDR_CTRL2: return 2'd1;
      default:                return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/md_io_channel.sv
// One controller port: DATA/CTRL registers, pin synchronizer, pin drive
// generation, read-back value and TH falling-edge interrupt latch.
module md_io_channel
  import md_io_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_data,
  input  logic       wr_ctrl,
  input  logic [7:0] din,
  input  logic       irq_ack,
  input  logic [6:0] pin_out,
  output logic [6:0] pin_in,
  output logic [6:0] pin_dir,
  output logic [7:0] rd_data,
  output logic [7:0] ctrl_q,
  output logic       pending
);

  logic [7:0]                  data_q;
  logic [SYNC_STAGES-1:0][6:0] sync_q;
  logic [6:0]                  synced;
  logic                        th_prev;
  logic                        th_edge;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= DATA_RST;
      ctrl_q <= CTRL_RST;
    end else begin
      if (wr_data) data_q <= din;
      if (wr_ctrl) ctrl_q <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{SYNC_RST}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_out};
    end
  end

  assign synced  = sync_q[SYNC_STAGES-1];
  assign pin_dir = ~ctrl_q[6:0];
  assign pin_in  = data_q[6:0] | pin_dir;

  always_comb begin
    rd_data = {data_q[7], 7'h00};
    for (int i = 0; i < 7; i++) begin
      rd_data[i] = ctrl_q[i] ? data_q[i] : synced[i];
    end
  end

  // th_prev tracks the pin even while disabled, so enabling TH as an input
  // never manufactures an edge from stale history.
  assign th_edge = th_prev & ~synced[6] & ctrl_q[7] & ~ctrl_q[6];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_prev <= 1'b1;
      pending <= 1'b0;
    end else begin
      th_prev <= synced[6];
      if (wr_ctrl && !din[7]) begin
        pending <= 1'b0;
      end else if (th_edge) begin
        pending <= 1'b1;
      end else if (irq_ack) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/md_io_regs.sv
// Controller I/O port register block: CPU address decode, registered read
// data and the combined TH external interrupt.
module md_io_regs
  import md_io_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sel,
  input  logic       we,
  input  logic [3:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       rd_valid,
  input  logic       export_n,
  input  logic       pal,
  input  logic       fdd,
  input  logic [6:0] port1_out,
  input  logic [6:0] port2_out,
  input  logic [6:0] port3_out,
  output logic [6:0] port1_in,
  output logic [6:0] port2_in,
  output logic [6:0] port3_in,
  output logic [6:0] port1_dir,
  output logic [6:0] port2_dir,
  output logic [6:0] port3_dir,
  output logic       ext_irq,
  input  logic       irq_ack
);

  reg_kind_e        kind;
  logic [1:0]       idx;
  logic [2:0][6:0]  pout;
  logic [2:0][6:0]  pin;
  logic [2:0][6:0]  pdir;
  logic [2:0][7:0]  ch_rd;
  logic [2:0][7:0]  ch_ctrl;
  logic [2:0]       ch_pend;
  logic [2:0]       wr_data;
  logic [2:0]       wr_ctrl;
  logic [7:0]       rd_mux;

  assign kind = decode_kind(addr);
  assign idx  = port_index(addr);

  assign pout = {port3_out, port2_out, port1_out};
  assign port1_in  = pin[0];
  assign port2_in  = pin[1];
  assign port3_in  = pin[2];
  assign port1_dir = pdir[0];
  assign port2_dir = pdir[1];
  assign port3_dir = pdir[2];

  always_comb begin
    wr_data = 3'b000;
    wr_ctrl = 3'b000;
    if (sel && we) begin
      if (kind == REG_DATA) wr_data[idx] = 1'b1;
      if (kind == REG_CTRL) wr_ctrl[idx] = 1'b1;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_ch
    md_io_channel #(.SYNC_STAGES(SYNC_STAGES)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .wr_data (wr_data[g]),
      .wr_ctrl (wr_ctrl[g]),
      .din     (din),
      .irq_ack (irq_ack),
      .pin_out (pout[g]),
      .pin_in  (pin[g]),
      .pin_dir (pdir[g]),
      .rd_data (ch_rd[g]),
      .ctrl_q  (ch_ctrl[g]),
      .pending (ch_pend[g])
    );
  end

  always_comb begin
    rd_mux = RXDATA_RD;
    case (kind)
      REG_VERSION: rd_mux = {~export_n, pal, fdd, 1'b0, 4'h0};
      REG_DATA:    rd_mux = ch_rd[idx];
      REG_CTRL:    rd_mux = ch_ctrl[idx];
      REG_TXDATA:  rd_mux = TXDATA_RD;
      REG_RXDATA:  rd_mux = RXDATA_RD;
      default:     rd_mux = SCTRL_RD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout     <= 8'h00;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= sel & ~we;
      if (sel && !we) dout <= rd_mux;
    end
  end

  assign ext_irq = |ch_pend;

endmodule

// File: tb/tb_md_io_regs.sv
// Directed bench for md_io_regs: register map, pin drive/readback, TH
// interrupt priorities and reset behaviour.
module tb_md_io_regs;

  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sel = 1'b0;
  logic       we = 1'b0;
  logic [3:0] addr = 4'h0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       rd_valid;
  logic       export_n = 1'b0;
  logic       pal = 1'b1;
  logic       fdd = 1'b0;
  logic [6:0] port1_out = 7'h7F;
  logic [6:0] port2_out = 7'h7F;
  logic [6:0] port3_out = 7'h7F;
  logic [6:0] port1_in, port2_in, port3_in;
  logic [6:0] port1_dir, port2_dir, port3_dir;
  logic       ext_irq;
  logic       irq_ack = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  md_io_regs #(.SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .sel(sel), .we(we), .addr(addr), .din(din),
    .dout(dout), .rd_valid(rd_valid), .export_n(export_n), .pal(pal), .fdd(fdd),
    .port1_out(port1_out), .port2_out(port2_out), .port3_out(port3_out),
    .port1_in(port1_in), .port2_in(port2_in), .port3_in(port3_in),
    .port1_dir(port1_dir), .port2_dir(port2_dir), .port3_dir(port3_dir),
    .ext_irq(ext_irq), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
    sel = 1'b1; we = 1'b1; addr = a; din = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic cpu_read(input string tag, input logic [3:0] a, input logic [7:0] exp);
    sel = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    sel = 1'b0;
    chk({tag, "_vld"}, {7'h0, rd_valid}, 8'h01);
    chk(tag, dout, exp);
  endtask

  initial begin
    #1 reset = 1'b1;
    #3;
    chk("rst_dout", dout, 8'h00);
    chk("rst_rdv", {7'h0, rd_valid}, 8'h00);
    chk("rst_dir1", {1'b0, port1_dir}, 8'h7F);
    chk("rst_dir3", {1'b0, port3_dir}, 8'h7F);
    chk("rst_in2", {1'b0, port2_in}, 8'h7F);
    chk("rst_irq", {7'h0, ext_irq}, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // version register and rd_valid pulse shape
    cpu_read("version", 4'h0, 8'hC0);
    @(negedge clk);
    chk("rdv_pulse", {7'h0, rd_valid}, 8'h00);

    cpu_write(4'h4, 8'h40);
    chk("dout_hold", dout, 8'hC0);
    cpu_write(4'h1, 8'h00);
    chk("p1_dir", {1'b0, port1_dir}, 8'h3F);
    chk("p1_in", {1'b0, port1_in}, 8'h3F);

    port1_out = 7'h2A;
    repeat (SS + 1) @(negedge clk);
    cpu_read("data1", 4'h1, 8'h2A);
    cpu_read("ctrl1", 4'h4, 8'h40);
    cpu_read("txdata", 4'hD, 8'hFF);
    cpu_read("rxdata", 4'h8, 8'h00);
    cpu_read("sctrl", 4'hC, 8'h00);

    // back-to-back write/read, port 3 fully console-driven
    cpu_write(4'h6, 8'h7F);
    cpu_write(4'h3, 8'h85);
    cpu_read("data3_b2b", 4'h3, 8'h85);
    chk("p3_dir", {1'b0, port3_dir}, 8'h00);
    chk("p3_in", {1'b0, port3_in}, 8'h05);

    // TH edge on port 2 and acknowledge
    cpu_write(4'h5, 8'h80);
    port2_out = 7'h3F;
    repeat (SS) @(negedge clk);
    chk("irq_early", {7'h0, ext_irq}, 8'h00);
    @(negedge clk);
    chk("irq_rise", {7'h0, ext_irq}, 8'h01);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    chk("irq_ack", {7'h0, ext_irq}, 8'h00);

    // edge coincident with ack: set wins
    port2_out = 7'h7F;
    repeat (4) @(negedge clk);
    chk("irq_rising_pin", {7'h0, ext_irq}, 8'h00);
    port2_out = 7'h3F;
    repeat (SS) @(negedge clk);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    chk("irq_set_wins", {7'h0, ext_irq}, 8'h01);
    @(negedge clk);
    chk("irq_set_hold", {7'h0, ext_irq}, 8'h01);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    chk("irq_ack2", {7'h0, ext_irq}, 8'h00);

    // disabling TH clears pending
    port2_out = 7'h7F;
    repeat (4) @(negedge clk);
    port2_out = 7'h3F;
    repeat (SS + 1) @(negedge clk);
    chk("irq_pre_dis", {7'h0, ext_irq}, 8'h01);
    cpu_write(4'h5, 8'h00);
    chk("irq_dis_clr", {7'h0, ext_irq}, 8'h00);

    // edge in the same cycle as the disabling write is dropped
    cpu_write(4'h5, 8'h80);
    port2_out = 7'h7F;
    repeat (4) @(negedge clk);
    port2_out = 7'h3F;
    repeat (SS) @(negedge clk);
    cpu_write(4'h5, 8'h00);
    chk("irq_dis_edge", {7'h0, ext_irq}, 8'h00);
    repeat (2) @(negedge clk);
    chk("irq_dis_edge2", {7'h0, ext_irq}, 8'h00);

    // TH output -> input with pin low: no edge
    cpu_write(4'h6, 8'h40);
    port3_out = 7'h00;
    repeat (SS + 3) @(negedge clk);
    chk("th_out_low", {7'h0, ext_irq}, 8'h00);
    cpu_write(4'h6, 8'h80);
    repeat (4) @(negedge clk);
    chk("th_switch", {7'h0, ext_irq}, 8'h00);
    chk("p3_dir_in", {1'b0, port3_dir}, 8'h7F);

    // pending interrupt, then reset in the middle of an access burst
    port2_out = 7'h7F;
    repeat (4) @(negedge clk);
    cpu_write(4'h5, 8'h80);
    port2_out = 7'h3F;
    repeat (SS + 2) @(negedge clk);
    chk("irq_pre_rst", {7'h0, ext_irq}, 8'h01);
    sel = 1'b1; we = 1'b1; addr = 4'h4; din = 8'hFF;
    @(negedge clk);
    chk("burst_dir1", {1'b0, port1_dir}, 8'h00);
    addr = 4'h1; din = 8'h00;
    @(negedge clk);
    we = 1'b0; addr = 4'h1;
    @(posedge clk);
    #1;
    chk("burst_rdv", {7'h0, rd_valid}, 8'h01);
    #1 reset = 1'b1;
    sel = 1'b1; we = 1'b1; addr = 4'h4; din = 8'hAA;
    #1;
    chk("mid_rdv", {7'h0, rd_valid}, 8'h00);
    chk("mid_dout", dout, 8'h00);
    chk("mid_dir1", {1'b0, port1_dir}, 8'h7F);
    chk("mid_in1", {1'b0, port1_in}, 8'h7F);
    chk("mid_dir2", {1'b0, port2_dir}, 8'h7F);
    chk("mid_in3", {1'b0, port3_in}, 8'h7F);
    chk("mid_irq", {7'h0, ext_irq}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_dir1", {1'b0, port1_dir}, 8'h7F);
    reset = 1'b0;
    sel = 1'b1; we = 1'b1; addr = 4'h4; din = 8'h55;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
    cpu_read("ctrl1_post_rst", 4'h4, 8'h55);
    cpu_read("ctrl2_post_rst", 4'h5, 8'h00);
    chk("irq_post_rst", {7'h0, ext_irq}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
